uart_rx_with_buffer: RTL and testbench

UART_RX_WITH_BUFFER -- requirements
Module: uart_rx_with_buffer

---
 rtl/uart_rx_with_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx_with_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_with_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_with_buffer
//
// 8N1 UART receiver feeding a show-ahead receive FIFO.
//
// Frames are detected on a two-flop synchronized copy of rx. Each bit is
// sampled in the middle of its bit time. Good bytes are pushed into the
// FIFO. A byte whose stop bit is low is discarded and raises frame_err.
//
// Parameters
//   CLK_PER_BIT : clk cycles per serial bit
//   DEPTH       : FIFO depth in bytes (power of two, 2..128)
//
// Ports
//   clk       : system clock, all state on its rising edge
//   rst       : asynchronous active-high reset
//   rx        : serial input, idle high, asynchronous to clk
//   rd_en     : pop the head byte (ignored while empty)
//   clr_err   : clear the sticky error flags
//   rd_data   : head byte (show-ahead), 8'h00 while empty
//   empty     : FIFO holds no bytes
//   full      : FIFO holds DEPTH bytes
//   count     : number of bytes held
//   overflow  : sticky, a received byte was dropped because the FIFO was full
//   frame_err : sticky, a stop bit was sampled low
// ---------------------------------------------------------------------------
module uart_rx_with_buffer #(
    parameter int CLK_PER_BIT = 10416,
    parameter int DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLK_PER_BIT);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    // -----------------------------------------------------------------------
    // Input synchronizer. It resets to the idle level so that a reset never
    // looks like a start bit.
    // -----------------------------------------------------------------------
    logic rx_meta_reg;
    logic rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s        <= rx_meta_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Receiver FSM
    // -----------------------------------------------------------------------
    logic [2:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    data_reg;

    logic sample;
    logic push;
    logic frame_set;

    // The sample point is the single cycle in which the bit counter is zero.
    assign sample    = (cnt_reg == '0);
    assign push      = (state_reg == STOP) && sample && rx_s;
    assign frame_set = (state_reg == STOP) && sample && !rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            data_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_reg <= START;
                        cnt_reg   <= HALF_LOAD;
                    end
                end
                START: begin
                    if (sample) begin
                        cnt_reg <= FULL_LOAD;
                        if (!rx_s) begin
                            state_reg   <= DATA;
                            bit_idx_reg <= '0;
                        end else begin
                            // Start bit gone high again by mid-bit: treat it as a glitch.
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DATA: begin
                    if (sample) begin
                        cnt_reg               <= FULL_LOAD;
                        data_reg[bit_idx_reg] <= rx_s;
                        bit_idx_reg           <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                STOP: begin
                    if (sample) begin
                        cnt_reg   <= FULL_LOAD;
                        state_reg <= rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A line stuck low (break) must not be taken for a new
                    // start bit; resume only after it returns to idle.
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Receive FIFO
    // -----------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;

    logic pop;
    logic push_accept;
    logic overflow_set;
    logic overflow_reg;
    logic frame_err_reg;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_CNT);
    assign count = count_reg;

    assign pop          = rd_en && !empty;
    // When full, a same-cycle pop frees the slot this push will occupy.
    assign push_accept  = push && (!full || rd_en);
    assign overflow_set = push && full && !rd_en;

    always_comb begin
        count_next = count_reg;
        case ({push_accept, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr_reg] <= data_reg;
        end
    end

    assign rd_data = empty ? 8'h00 : mem[rd_ptr_reg];

    // -----------------------------------------------------------------------
    // Sticky error flags: a set event in the same cycle beats clr_err.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
            if (frame_set) begin
                frame_err_reg <= 1'b1;
            end else if (clr_err) begin
                frame_err_reg <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_with_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_with_buffer
//
// Directed bench for uart_rx_with_buffer with CLK_PER_BIT=16, DEPTH=16.
// Serial frames are driven bit by bit. Results are compared with values
// worked out by hand. Inputs change 1 time unit after a rising edge, and
// outputs are checked at that same offset.
// ---------------------------------------------------------------------------
module tb_uart_rx_with_buffer;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       frame_err;

    int vectors = 0;
    int errors  = 0;

    uart_rx_with_buffer #(
        .CLK_PER_BIT (CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
    endtask

    // Sends one frame. The stop sample falls on the 11th edge after the stop
    // bit is driven. When pop_on_push is set, rd_en is raised for exactly the
    // cycle that ends on that edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic pop_on_push);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        rx = stop_bit;
        cyc(10);
        rd_en = pop_on_push;
        cyc(1);
        rd_en = 1'b0;
        cyc(5);
        if (stop_bit) rx = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        #1;
        $display("reset state check");
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // Well-formed 0x55
        send_byte(8'h55, 1'b1, 1'b0);
        cyc(2);
        $display("frame 0x55: empty=%0b count=%0d rd_data=%02h", empty, count, rd_data);
        check("b55_empty", empty, 0);
        check("b55_count", count, 1);
        check("b55_rd_data", rd_data, 8'h55);
        pop_one();
        check("b55_pop_empty", empty, 1);
        check("b55_pop_rd_data", rd_data, 8'h00);

        // Start glitch: 4 clk low
        rx = 1'b0;
        cyc(4);
        rx = 1'b1;
        cyc(20);
        $display("glitch: empty=%0b frame_err=%0b", empty, frame_err);
        check("glitch_empty", empty, 1);
        check("glitch_frame_err", frame_err, 0);
        check("glitch_state_idle", dut.state_reg, 3'd0);

        // 0xA5 with a low stop bit, line low 40 clk, then 0x3C
        send_byte(8'hA5, 1'b0, 1'b0);
        cyc(24);
        rx = 1'b1;
        cyc(4);
        check("ferr_set", frame_err, 1);
        check("ferr_nopush", empty, 1);
        send_byte(8'h3C, 1'b1, 1'b0);
        cyc(2);
        $display("frame err then 0x3C: frame_err=%0b count=%0d rd_data=%02h", frame_err, count, rd_data);
        check("ferr_sticky", frame_err, 1);
        check("ferr_count", count, 1);
        check("ferr_rd_data", rd_data, 8'h3C);
        pop_one();
        check("ferr_pop_empty", empty, 1);
        pulse_clr();
        check("ferr_clr", frame_err, 0);

        // 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, 1'b0);
        cyc(2);
        $display("17 bytes: full=%0b count=%0d overflow=%0b", full, count, overflow);
        check("ovf_full", full, 1);
        check("ovf_count", count, 16);
        check("ovf_flag", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            $display("read %0d: rd_data=%02h", i, rd_data);
            check("ovf_read", rd_data, 32'(i));
            pop_one();
        end
        check("ovf_drained", empty, 1);
        check("ovf_still_set", overflow, 1);
        pulse_clr();
        check("ovf_clr", overflow, 0);

        // Full FIFO, pop in the same cycle that 0x7E is pushed
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1, 1'b0);
        cyc(2);
        check("pp_prefull", full, 1);
        send_byte(8'h7E, 1'b1, 1'b1);
        cyc(2);
        $display("push+pop while full: count=%0d overflow=%0b", count, overflow);
        check("pp_count", count, 16);
        check("pp_overflow", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            $display("read %0d: rd_data=%02h", i, rd_data);
            check("pp_read", rd_data, (i == 15) ? 32'h7E : 32'(8'h21 + i));
            pop_one();
        end
        check("pp_drained", empty, 1);

        // Reset in the middle of data bit 3 of 0x81, with one byte buffered
        send_byte(8'h99, 1'b1, 1'b0);
        cyc(2);
        check("rstmid_pre_count", count, 1);
        rx = 1'b0;
        cyc(CPB);
        rx = 1'b1; cyc(CPB);
        rx = 1'b0; cyc(CPB);
        rx = 1'b0; cyc(CPB);
        rx = 1'b0;
        cyc(5);
        #3 rst = 1'b1;
        #1;
        $display("async reset: empty=%0b count=%0d rd_data=%02h", empty, count, rd_data);
        check("rstmid_empty", empty, 1);
        check("rstmid_count", count, 0);
        check("rstmid_full", full, 0);
        check("rstmid_rd_data", rd_data, 8'h00);
        check("rstmid_overflow", overflow, 0);
        check("rstmid_frame_err", frame_err, 0);
        check("rstmid_state", dut.state_reg, 3'd0);
        @(posedge clk);
        #1;
        rx = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(4);
        send_byte(8'hC3, 1'b1, 1'b0);
        cyc(2);
        $display("after reset 0xC3: count=%0d rd_data=%02h", count, rd_data);
        check("post_rst_count", count, 1);
        check("post_rst_rd_data", rd_data, 8'hC3);
        check("post_rst_frame_err", frame_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
